// File: rtl/regfile_2r1w_if.sv
// Operand register-file bus: write port, two read ports and the bulk-clear handshake.
// Parameters: WIDTH (data bits), DEPTH (entries); address width AW = $clog2(DEPTH).
// Signals:
//   write, writenum, data_in  write request (master -> slave)
//   readnum_a, readnum_b      read addresses (master -> slave)
//   data_out_a, data_out_b    combinational read data (slave -> master)
//   clear_req                 start bulk clear (master -> slave)
//   clear_busy, write_drop    clear engine running / write discarded (slave -> master)
interface regfile_2r1w_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             write;
  logic [AW-1:0]    writenum;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic [WIDTH-1:0] data_out_a;
  logic [WIDTH-1:0] data_out_b;
  logic             clear_req;
  logic             clear_busy;
  logic             write_drop;

  modport master (
    output write, writenum, data_in, readnum_a, readnum_b, clear_req,
    input  data_out_a, data_out_b, clear_busy, write_drop
  );

  modport slave (
    input  write, writenum, data_in, readnum_a, readnum_b, clear_req,
    output data_out_a, data_out_b, clear_busy, write_drop
  );
endinterface

// File: rtl/regfile_2r1w.sv
// WIDTH x DEPTH datapath register file: one write port, two combinational read ports,
// and a sequenced bulk-clear engine that writes CLEAR_VAL into every entry, one per cycle.
// Ports: clk, rst_n (async active-low), bus (regfile_2r1w_if.slave).
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  regfile_2r1w_if.slave  bus
);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             clear_busy_q, clear_busy_d;
  logic             write_drop_q, write_drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             wr_accept;
  logic [WIDTH-1:0] rd_a_c, rd_b_c;

  // Widened compares stay meaningful when DEPTH is not a power of two.
  assign wr_accept = bus.write && (state_q == IDLE) && ({1'b0, bus.writenum} < DEPTH_W);

  // Next state: host writes in IDLE, clear engine owns the write port in CLEAR.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mem_d        = mem_q;
    write_drop_d = bus.write && !wr_accept;
    case (state_q)
      IDLE: begin
        if (wr_accept) mem_d[bus.writenum] = bus.data_in;
        if (bus.clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = CLEAR_VAL;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    clear_busy_d = (state_d == CLEAR);
  end

  // State, pointer, status flags and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      clear_busy_q <= 1'b0;
      write_drop_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_busy_q <= clear_busy_d;
      write_drop_q <= write_drop_d;
      mem_q        <= mem_d;
    end
  end

  // Combinational read ports; out-of-range addresses read as zero.
  always_comb begin
    rd_a_c = '0;
    rd_b_c = '0;
    if ({1'b0, bus.readnum_a} < DEPTH_W) rd_a_c = mem_q[bus.readnum_a];
    if ({1'b0, bus.readnum_b} < DEPTH_W) rd_b_c = mem_q[bus.readnum_b];
`ifdef REGFILE_BYPASS_EN
    // Forward only host writes that will actually land this cycle.
    if (wr_accept && (bus.writenum == bus.readnum_a)) rd_a_c = bus.data_in;
    if (wr_accept && (bus.writenum == bus.readnum_b)) rd_b_c = bus.data_in;
`endif
  end

  assign bus.data_out_a = rd_a_c;
  assign bus.data_out_b = rd_b_c;
  assign bus.clear_busy = clear_busy_q;
  assign bus.write_drop = write_drop_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized + directed bench for regfile_2r1w: one DEPTH=8 instance and one DEPTH=6 instance
// (CLEAR_VAL=16'h5A5A) share stimulus and are checked against an array-based model every cycle.
module tb_regfile_2r1w;
  localparam logic [15:0] CV6 = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        w, clr;
  logic [2:0]  wn, ra, rb;
  logic [15:0] din;

  regfile_2r1w_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
  regfile_2r1w_if #(.WIDTH(16), .DEPTH(6)) bus6 ();

  assign bus8.write = w;   assign bus6.write = w;
  assign bus8.writenum = wn; assign bus6.writenum = wn;
  assign bus8.data_in = din; assign bus6.data_in = din;
  assign bus8.readnum_a = ra; assign bus6.readnum_a = ra;
  assign bus8.readnum_b = rb; assign bus6.readnum_b = rb;
  assign bus8.clear_req = clr; assign bus6.clear_req = clr;

  regfile_2r1w #(.WIDTH(16), .DEPTH(8), .CLEAR_VAL(16'h0000)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));
  regfile_2r1w #(.WIDTH(16), .DEPTH(6), .CLEAR_VAL(CV6)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6));

  // Reference model: contents, remaining clear cycles, status flags per instance.
  logic [15:0] m_mem [2][8];
  int          m_left [2];
  bit          m_busy [2];
  bit          m_drop [2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] cval(input int k);
    return (k == 0) ? 16'h0000 : CV6;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0000;
      m_left[k] = 0;
      m_busy[k] = 1'b0;
      m_drop[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d;
      bit acc;
      d   = dep(k);
      acc = w && !m_busy[k] && (int'(wn) < d);
      m_drop[k] = w && !acc;
      if (m_busy[k]) begin
        m_mem[k][d - m_left[k]] = cval(k);
        m_left[k] = m_left[k] - 1;
        m_busy[k] = (m_left[k] != 0);
      end else begin
        if (acc) m_mem[k][wn] = din;
        if (clr) begin
          m_left[k] = d;
          m_busy[k] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] rn);
    if (int'(rn) >= dep(k)) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (w && !m_busy[k] && (int'(wn) < dep(k)) && (wn == rn)) return din;
`endif
    return m_mem[k][rn];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("d8.out_a", bus8.data_out_a, exp_rd(0, ra));
    check("d8.out_b", bus8.data_out_b, exp_rd(0, rb));
    check("d8.busy",  16'(bus8.clear_busy), 16'(m_busy[0]));
    check("d8.drop",  16'(bus8.write_drop), 16'(m_drop[0]));
    check("d6.out_a", bus6.data_out_a, exp_rd(1, ra));
    check("d6.out_b", bus6.data_out_b, exp_rd(1, rb));
    check("d6.busy",  16'(bus6.clear_busy), 16'(m_busy[1]));
    check("d6.drop",  16'(bus6.write_drop), 16'(m_drop[1]));
  endtask

  // One clock: model sees the inputs the DUT sampled, then new inputs, then compare mid-cycle.
  task automatic cyc(input bit iw, input logic [2:0] iwn, input logic [15:0] idin,
                     input logic [2:0] ira, input logic [2:0] irb,
                     input bit iclr, input bit irst);
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    w = iw; wn = iwn; din = idin; ra = ira; rb = irb; clr = iclr; rst_n = irst;
    if (!irst) model_reset();
    @(negedge clk);
    compare_all();
  endtask

  int cnt8, cnt6;

  initial begin
    rst_n = 1'b0; w = 0; clr = 0; wn = 0; ra = 0; rb = 0; din = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rst_busy", 16'(bus8.clear_busy), 16'h0);
    check("rst_rd",   bus8.data_out_a, 16'h0);

    // Single write, read back on both ports.
    cyc(1, 3, 16'hABCD, 0, 0, 0, 1);
    cyc(0, 0, 0, 3, 3, 0, 1);
    check("t1_a", bus8.data_out_a, 16'hABCD);
    check("t1_b", bus8.data_out_b, 16'hABCD);
    cyc(0, 0, 0, 0, 7, 0, 1);
    check("t1_other", bus8.data_out_b, 16'h0000);

    // Two distinct registers on the two ports.
    cyc(1, 1, 16'h0001, 0, 0, 0, 1);
    cyc(1, 6, 16'hF00F, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 6, 0, 1);
    check("t2_a", bus8.data_out_a, 16'h0001);
    check("t2_b", bus8.data_out_b, 16'hF00F);

    // Same-cycle read of the register being written.
    cyc(1, 2, 16'h1234, 2, 0, 0, 1);
`ifdef REGFILE_BYPASS_EN
    check("t3_fwd", bus8.data_out_a, 16'h1234);
`else
    check("t3_fwd", bus8.data_out_a, 16'h0000);
`endif

    // Fill, then bulk clear with a write attempted mid-clear.
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 16'(i * 16'h1111 + 1), 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cnt8 = 0; cnt6 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc((i == 2), 5, 16'hDEAD, 3'(i), 5, 0, 1);
      if (bus8.clear_busy) cnt8++;
      if (bus6.clear_busy) cnt6++;
      if (i == 3) check("t4_drop", 16'(bus8.write_drop), 16'h1);
      if (i == 4) check("t4_drop_end", 16'(bus8.write_drop), 16'h0);
    end
    check("t4_busy8", 16'(cnt8), 16'd8);
    check("t4_busy6", 16'(cnt6), 16'd6);
    cyc(0, 0, 0, 5, 7, 0, 1);
    check("t4_r5", bus8.data_out_a, 16'h0000);
    check("t4_r7", bus8.data_out_b, 16'h0000);
    check("t4_cv6", bus6.data_out_a, CV6);

    // Reset in the middle of a clear.
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 16'(16'h0100 + i), 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 7, 1, 0, 1);
    check("t5_pre", bus8.data_out_a, 16'h0107);
    cyc(0, 0, 0, 7, 1, 0, 0);
    check("t5_busy", 16'(bus8.clear_busy), 16'h0);
    check("t5_rd",   bus8.data_out_a, 16'h0000);
    check("t5_rd6",  bus6.data_out_b, 16'h0000);
    cnt8 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 7, 1, 0, 1);
      if (bus8.clear_busy || bus6.clear_busy) cnt8++;
    end
    check("t5_no_resume", 16'(cnt8), 16'd0);

    // Out-of-range address on the 6-entry instance.
    cyc(1, 7, 16'hBEEF, 7, 6, 0, 1);
    cyc(0, 0, 0, 7, 6, 0, 1);
    check("t6_drop6", 16'(bus6.write_drop), 16'h1);
    check("t6_rd6",   bus6.data_out_a, 16'h0000);
    check("t6_drop8", 16'(bus8.write_drop), 16'h0);
    check("t6_rd8",   bus8.data_out_a, 16'hBEEF);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
